core_dispatcher: RTL and testbench
==================================

Name: core_dispatcher

Overview:
Sequences packets across the N parallel packetfilter cores. Grants the snooper to one free core at a time, round-robin. Records the order in which cores received packets. Hands the forwarder to cores strictly in that order, skipping cores whose packet was rejected. Sits between the snooper/forwarder handshakes and the per-core ready/ack/done signals, and drives the mux selects.

Parameters:
N, 4, number of filter cores (2..16)
SEL_WIDTH, clog2(N) (min 1), width of core index; derived, not set manually

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
core_rdy_for_sn  in  N  core i has empty packet memory and can accept a packet
core_sn_ack  out  N  one-cycle pulse to core i when it is granted the snooper
core_sn_done  out  N  one-cycle pulse to core i when its packet is fully written
core_rdy_for_fwd  in  N  core i accepted its packet and can be read out
core_rej  in  N  one-cycle pulse: core i rejected its packet
core_fwd_ack  out  N  one-cycle pulse to core i when the forwarder starts reading it
core_fwd_done  out  N  one-cycle pulse to core i when forwarding completes
rdy_for_sn  out  1  to snooper: a core is reserved
rdy_for_sn_ack  in  1  snooper pulse: packet start accepted
sn_done  in  1  snooper pulse: packet end
rdy_for_fwd  out  1  to forwarder: head core has a packet
rdy_for_fwd_ack  in  1  forwarder pulse: read started
fwd_done  in  1  forwarder pulse: read finished
sn_sel  out  SEL_WIDTH  core index for the snoop write mux
fwd_sel  out  SEL_WIDTH  core index for the forward read mux
inflight_cnt  out  SEL_WIDTH+1  number of cores in the order FIFO

Behaviour:
- Reset: all outputs 0; both FSMs in IDLE; FIFO empty; inflight and rej_pending bit vectors cleared; round-robin pointer at 0.
- in_flight[i] is set when core i is pushed to the order FIFO and cleared when it is popped.
- eligible = core_rdy_for_sn & ~in_flight & ~(sn-owned core).

Snoop FSM (SN_IDLE, SN_OFFER, SN_BUSY):
- SN_IDLE:
  - If eligible is non-zero, choose the first set bit at or after rr_ptr, wrapping. Register it into sn_sel, set rdy_for_sn=1, go to SN_OFFER.
  - The grant is visible 1 cycle after eligibility is seen.
- SN_OFFER:
  - Hold rdy_for_sn=1 and sn_sel.
  - On rdy_for_sn_ack: rdy_for_sn=0; pulse core_sn_ack[sn_sel] next cycle; go to SN_BUSY.
  - If core_rdy_for_sn[sn_sel] drops before the ack: withdraw (rdy_for_sn=0) and return to SN_IDLE.
- SN_BUSY:
  - On sn_done: pulse core_sn_done[sn_sel]; push sn_sel into the FIFO; rr_ptr = sn_sel+1 mod N; go to SN_IDLE.
  - No new offer is made in the same cycle.

Order FIFO:
- N entries; pointers are SEL_WIDTH-bit and wrap at N.
- The in_flight mask guarantees it can never overfill.
- A push when full is a design error (simulation assertion).
- A push and a pop in the same cycle are both performed; inflight_cnt stays unchanged.

Reject tracking:
- core_rej[i] sets rej_pending[i]. The set has priority over a same-cycle clear of a different core.
- core_rej for a core not in flight is ignored.

Forward FSM (FW_IDLE, FW_OFFER, FW_BUSY); head = FIFO head index:
- FW_IDLE, FIFO non-empty:
  - If rej_pending[head]: pop, clear rej_pending[head] and in_flight[head]; stay in FW_IDLE. One skip per cycle.
  - Else if core_rdy_for_fwd[head]: fwd_sel=head, rdy_for_fwd=1, go to FW_OFFER.
  - Otherwise wait. Later cores never overtake the head.
- FW_OFFER:
  - On rdy_for_fwd_ack: rdy_for_fwd=0; pulse core_fwd_ack[fwd_sel]; go to FW_BUSY.
- FW_BUSY:
  - On fwd_done: pulse core_fwd_done[fwd_sel]; pop; clear in_flight; go to FW_IDLE.
- Ack/done pulses arriving in a state that does not expect them are ignored.

General:
- Both FSMs run concurrently. sn_sel and fwd_sel may differ in any cycle.
- Reset mid-packet: everything returns to reset values immediately. Any core_* pulse owed is not issued.

Test Plan:
- Cores 0-3 all ready, snooper acks each offer, 4 sn_done pulses → sn_sel sequence 0,1,2,3; FIFO order 0,1,2,3; inflight_cnt=4; no 5th offer.
- FIFO holds 0,1,2; core 2 asserts rdy_for_fwd first, then core 0 → rdy_for_fwd rises only after core 0 is ready, with fwd_sel=0; core 2 is served third.
- FIFO holds 1,3; core_rej[1] pulse, core 3 ready → head 1 popped with no forward pulses; then fwd_sel=3 and rdy_for_fwd=1 one cycle later.
- After a grant to core 2, rr_ptr=3; cores 0 and 3 ready → next grant is core 3, then core 0.
- sn_done and fwd_done in the same cycle with inflight_cnt=2 → one push, one pop; inflight_cnt stays 2.
- rst asserted in SN_BUSY and FW_BUSY → all outputs 0 asynchronously, inflight_cnt=0; after release, the first grant goes to core 0.

Source files
------------

// File: rtl/core_dispatcher.sv
// core_dispatcher: grants the snooper to free filter cores round-robin, records
// the order in which cores received packets, and hands the forwarder to cores
// strictly in that order, skipping cores whose packet was rejected.
module core_dispatcher #(
   parameter  int N         = 4,
   localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         core_rdy_for_sn,
   output logic [N-1:0]         core_sn_ack,
   output logic [N-1:0]         core_sn_done,
   input  logic [N-1:0]         core_rdy_for_fwd,
   input  logic [N-1:0]         core_rej,
   output logic [N-1:0]         core_fwd_ack,
   output logic [N-1:0]         core_fwd_done,
   output logic                 rdy_for_sn,
   input  logic                 rdy_for_sn_ack,
   input  logic                 sn_done,
   output logic                 rdy_for_fwd,
   input  logic                 rdy_for_fwd_ack,
   input  logic                 fwd_done,
   output logic [SEL_WIDTH-1:0] sn_sel,
   output logic [SEL_WIDTH-1:0] fwd_sel,
   output logic [SEL_WIDTH:0]   inflight_cnt
);

   typedef enum logic [1:0] {SN_IDLE, SN_OFFER, SN_BUSY} sn_state_e;
   typedef enum logic [1:0] {FW_IDLE, FW_OFFER, FW_BUSY} fw_state_e;

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N - 1);
   localparam logic [SEL_WIDTH:0]   CNT_ONE  = (SEL_WIDTH+1)'(1);
   localparam logic [SEL_WIDTH:0]   CNT_FULL = (SEL_WIDTH+1)'(N);

   // Core indices wrap at N, which need not be a power of two.
   function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + SEL_WIDTH'(1);
   endfunction

   function automatic logic [N-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
      logic [N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // snoop side
   sn_state_e            sn_state_q, sn_state_d;
   logic [SEL_WIDTH-1:0] sn_sel_q, sn_sel_d;
   logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic                 rdy_for_sn_q, rdy_for_sn_d;
   logic [N-1:0]         sn_ack_q, sn_ack_d;
   logic [N-1:0]         sn_done_q, sn_done_d;
   logic                 push;

   // forward side
   fw_state_e            fw_state_q, fw_state_d;
   logic [SEL_WIDTH-1:0] fwd_sel_q, fwd_sel_d;
   logic                 rdy_for_fwd_q, rdy_for_fwd_d;
   logic [N-1:0]         fwd_ack_q, fwd_ack_d;
   logic [N-1:0]         fwd_done_q, fwd_done_d;
   logic                 pop;

   // order FIFO and per-core tracking
   logic [SEL_WIDTH-1:0] fifo_q [N];
   logic [SEL_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [SEL_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [SEL_WIDTH:0]   cnt_q, cnt_d;
   logic [N-1:0]         in_flight_q, in_flight_d;
   logic [N-1:0]         rej_q, rej_d;
   logic [SEL_WIDTH-1:0] head;
   logic [N-1:0]         push_mask, pop_mask;

   // round-robin pick
   logic [N-1:0]         sn_own, eligible;
   logic [SEL_WIDTH-1:0] pick, cand;
   logic                 pick_vld;

   assign head = fifo_q[rd_ptr_q];

   // First eligible core at or after rr_ptr, wrapping; a core already in the
   // FIFO or currently owned by the snooper is never offered again.
   always_comb begin
      sn_own = '0;
      if (sn_state_q != SN_IDLE) sn_own = onehot(sn_sel_q);
      eligible = core_rdy_for_sn & ~in_flight_q & ~sn_own;
      pick     = rr_ptr_q;
      pick_vld = 1'b0;
      cand     = rr_ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!pick_vld && eligible[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
         cand = next_idx(cand);
      end
   end

   // Snoop FSM next state: offer, ack, then wait for packet end and push.
   always_comb begin
      sn_state_d   = sn_state_q;
      sn_sel_d     = sn_sel_q;
      rr_ptr_d     = rr_ptr_q;
      rdy_for_sn_d = rdy_for_sn_q;
      sn_ack_d     = '0;
      sn_done_d    = '0;
      push         = 1'b0;
      case (sn_state_q)
         SN_IDLE: begin
            if (pick_vld) begin
               sn_sel_d     = pick;
               rdy_for_sn_d = 1'b1;
               sn_state_d   = SN_OFFER;
            end
         end
         SN_OFFER: begin
            if (rdy_for_sn_ack) begin
               rdy_for_sn_d = 1'b0;
               sn_ack_d     = onehot(sn_sel_q);
               sn_state_d   = SN_BUSY;
            end else if (!core_rdy_for_sn[sn_sel_q]) begin
               // core lost its free buffer before the snooper took it
               rdy_for_sn_d = 1'b0;
               sn_state_d   = SN_IDLE;
            end
         end
         SN_BUSY: begin
            if (sn_done) begin
               sn_done_d  = onehot(sn_sel_q);
               push       = 1'b1;
               rr_ptr_d   = next_idx(sn_sel_q);
               sn_state_d = SN_IDLE;
            end
         end
         default: begin
            rdy_for_sn_d = 1'b0;
            sn_state_d   = SN_IDLE;
         end
      endcase
   end

   // Forward FSM next state: serve FIFO head only, dropping rejected heads.
   always_comb begin
      fw_state_d    = fw_state_q;
      fwd_sel_d     = fwd_sel_q;
      rdy_for_fwd_d = rdy_for_fwd_q;
      fwd_ack_d     = '0;
      fwd_done_d    = '0;
      pop           = 1'b0;
      case (fw_state_q)
         FW_IDLE: begin
            if (cnt_q != '0) begin
               if (rej_q[head]) begin
                  pop = 1'b1;
               end else if (core_rdy_for_fwd[head]) begin
                  fwd_sel_d     = head;
                  rdy_for_fwd_d = 1'b1;
                  fw_state_d    = FW_OFFER;
               end
            end
         end
         FW_OFFER: begin
            if (rdy_for_fwd_ack) begin
               rdy_for_fwd_d = 1'b0;
               fwd_ack_d     = onehot(fwd_sel_q);
               fw_state_d    = FW_BUSY;
            end
         end
         FW_BUSY: begin
            if (fwd_done) begin
               fwd_done_d = onehot(fwd_sel_q);
               pop        = 1'b1;
               fw_state_d = FW_IDLE;
            end
         end
         default: begin
            rdy_for_fwd_d = 1'b0;
            fw_state_d    = FW_IDLE;
         end
      endcase
   end

   // FIFO pointers, occupancy and per-core in-flight / reject flags.
   // A reject on the core being popped this cycle is dropped: the core is
   // leaving, and a stale flag would wrongly skip its next packet.
   always_comb begin
      push_mask   = push ? onehot(sn_sel_q) : '0;
      pop_mask    = pop  ? onehot(head)     : '0;
      in_flight_d = (in_flight_q | push_mask) & ~pop_mask;
      rej_d       = (rej_q | (core_rej & in_flight_q)) & ~pop_mask;
      wr_ptr_d    = push ? next_idx(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = pop  ? next_idx(rd_ptr_q) : rd_ptr_q;
      cnt_d       = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
   end

   // Snoop FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sn_state_q   <= SN_IDLE;
         sn_sel_q     <= '0;
         rr_ptr_q     <= '0;
         rdy_for_sn_q <= 1'b0;
         sn_ack_q     <= '0;
         sn_done_q    <= '0;
      end else begin
         sn_state_q   <= sn_state_d;
         sn_sel_q     <= sn_sel_d;
         rr_ptr_q     <= rr_ptr_d;
         rdy_for_sn_q <= rdy_for_sn_d;
         sn_ack_q     <= sn_ack_d;
         sn_done_q    <= sn_done_d;
      end
   end

   // Forward FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fw_state_q    <= FW_IDLE;
         fwd_sel_q     <= '0;
         rdy_for_fwd_q <= 1'b0;
         fwd_ack_q     <= '0;
         fwd_done_q    <= '0;
      end else begin
         fw_state_q    <= fw_state_d;
         fwd_sel_q     <= fwd_sel_d;
         rdy_for_fwd_q <= rdy_for_fwd_d;
         fwd_ack_q     <= fwd_ack_d;
         fwd_done_q    <= fwd_done_d;
      end
   end

   // Order FIFO storage and tracking registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) fifo_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         in_flight_q <= '0;
         rej_q       <= '0;
      end else begin
         if (push) fifo_q[wr_ptr_q] <= sn_sel_q;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         in_flight_q <= in_flight_d;
         rej_q       <= rej_d;
      end
   end

   // The in-flight mask keeps a full FIFO from ever seeing another push.
   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                    !(push && (cnt_q == CNT_FULL)));

   assign core_sn_ack   = sn_ack_q;
   assign core_sn_done  = sn_done_q;
   assign core_fwd_ack  = fwd_ack_q;
   assign core_fwd_done = fwd_done_q;
   assign rdy_for_sn    = rdy_for_sn_q;
   assign rdy_for_fwd   = rdy_for_fwd_q;
   assign sn_sel        = sn_sel_q;
   assign fwd_sel       = fwd_sel_q;
   assign inflight_cnt  = cnt_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// tb_core_dispatcher: per-cycle directed vectors for core_dispatcher (N=4).
// Each vector holds the inputs for one cycle and the outputs expected just
// after the following rising edge.
module tb_core_dispatcher;
   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic [3:0] core_rdy_for_sn, core_rdy_for_fwd, core_rej;
   logic [3:0] core_sn_ack, core_sn_done, core_fwd_ack, core_fwd_done;
   logic       rdy_for_sn, rdy_for_sn_ack, sn_done;
   logic       rdy_for_fwd, rdy_for_fwd_ack, fwd_done;
   logic [1:0] sn_sel, fwd_sel;
   logic [2:0] inflight_cnt;

   int checks = 0;
   int errors = 0;

   core_dispatcher #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .core_rdy_for_sn(core_rdy_for_sn), .core_sn_ack(core_sn_ack),
      .core_sn_done(core_sn_done), .core_rdy_for_fwd(core_rdy_for_fwd),
      .core_rej(core_rej), .core_fwd_ack(core_fwd_ack),
      .core_fwd_done(core_fwd_done), .rdy_for_sn(rdy_for_sn),
      .rdy_for_sn_ack(rdy_for_sn_ack), .sn_done(sn_done),
      .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
      .fwd_done(fwd_done), .sn_sel(sn_sel), .fwd_sel(fwd_sel),
      .inflight_cnt(inflight_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {rdy_for_sn_ack, sn_done, rdy_for_fwd_ack, fwd_done}
   typedef struct {
      logic [3:0] rsn, rfw, rej, ctl;
      logic [3:0] sa, sd, fa, fd;
      logic       rs, rf;
      logic [1:0] ss, fs;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl [26];

   function automatic vec_t mk(input int rsn, rfw, rej, ctl, sa, sd, fa, fd,
                               input int rs, rf, ss, fs, cnt);
      vec_t v;
      v.rsn = 4'(rsn); v.rfw = 4'(rfw); v.rej = 4'(rej); v.ctl = 4'(ctl);
      v.sa  = 4'(sa);  v.sd  = 4'(sd);  v.fa  = 4'(fa);  v.fd  = 4'(fd);
      v.rs  = 1'(rs);  v.rf  = 1'(rf);  v.ss  = 2'(ss);  v.fs  = 2'(fs);
      v.cnt = 3'(cnt);
      return v;
   endfunction

   task automatic check(input string name, input vec_t e);
      checks++;
      if ({core_sn_ack, core_sn_done, core_fwd_ack, core_fwd_done, rdy_for_sn,
           rdy_for_fwd, sn_sel, fwd_sel, inflight_cnt} !==
          {e.sa, e.sd, e.fa, e.fd, e.rs, e.rf, e.ss, e.fs, e.cnt}) begin
         errors++;
         $display("FAIL %s: got sa=%b sd=%b fa=%b fd=%b rs=%b rf=%b ss=%0d fs=%0d cnt=%0d want sa=%b sd=%b fa=%b fd=%b rs=%b rf=%b ss=%0d fs=%0d cnt=%0d",
                  name, core_sn_ack, core_sn_done, core_fwd_ack, core_fwd_done,
                  rdy_for_sn, rdy_for_fwd, sn_sel, fwd_sel, inflight_cnt,
                  e.sa, e.sd, e.fa, e.fd, e.rs, e.rf, e.ss, e.fs, e.cnt);
      end
   endtask

   task automatic step(input string name, input vec_t v);
      core_rdy_for_sn  = v.rsn;
      core_rdy_for_fwd = v.rfw;
      core_rej         = v.rej;
      {rdy_for_sn_ack, sn_done, rdy_for_fwd_ack, fwd_done} = v.ctl;
      @(posedge clk);
      #1;
      check(name, v);
   endtask

   initial begin
      // all four cores free: grants 0,1,2,3, then no fifth offer;
      // forward with core 2 ready before head 0 and core 1 rejected
      //            rsn rfw rej ctl  sa sd fa fd  rs rf ss fs cnt
      tbl[0]  = mk(15, 0,  0,  0,   0, 0, 0, 0,  1, 0, 0, 0, 0);
      tbl[1]  = mk(15, 0,  0,  8,   1, 0, 0, 0,  0, 0, 0, 0, 0);
      tbl[2]  = mk(15, 0,  0,  4,   0, 1, 0, 0,  0, 0, 0, 0, 1);
      tbl[3]  = mk(15, 0,  0,  0,   0, 0, 0, 0,  1, 0, 1, 0, 1);
      tbl[4]  = mk(15, 0,  0,  8,   2, 0, 0, 0,  0, 0, 1, 0, 1);
      tbl[5]  = mk(15, 0,  0,  4,   0, 2, 0, 0,  0, 0, 1, 0, 2);
      tbl[6]  = mk(15, 0,  0,  0,   0, 0, 0, 0,  1, 0, 2, 0, 2);
      tbl[7]  = mk(15, 0,  0,  8,   4, 0, 0, 0,  0, 0, 2, 0, 2);
      tbl[8]  = mk(15, 0,  0,  4,   0, 4, 0, 0,  0, 0, 2, 0, 3);
      tbl[9]  = mk(15, 0,  0,  0,   0, 0, 0, 0,  1, 0, 3, 0, 3);
      tbl[10] = mk(15, 0,  0,  8,   8, 0, 0, 0,  0, 0, 3, 0, 3);
      tbl[11] = mk(15, 0,  0,  4,   0, 8, 0, 0,  0, 0, 3, 0, 4);
      tbl[12] = mk(15, 0,  0,  0,   0, 0, 0, 0,  0, 0, 3, 0, 4);
      tbl[13] = mk(0,  4,  2,  0,   0, 0, 0, 0,  0, 0, 3, 0, 4);
      tbl[14] = mk(0,  4,  0,  0,   0, 0, 0, 0,  0, 0, 3, 0, 4);
      tbl[15] = mk(0,  5,  0,  0,   0, 0, 0, 0,  0, 1, 3, 0, 4);
      tbl[16] = mk(0,  5,  0,  2,   0, 0, 1, 0,  0, 0, 3, 0, 4);
      tbl[17] = mk(0,  5,  0,  1,   0, 0, 0, 1,  0, 0, 3, 0, 3);
      tbl[18] = mk(0,  4,  0,  0,   0, 0, 0, 0,  0, 0, 3, 0, 2);
      tbl[19] = mk(0,  4,  0,  0,   0, 0, 0, 0,  0, 1, 3, 2, 2);
      tbl[20] = mk(0,  4,  0,  2,   0, 0, 4, 0,  0, 0, 3, 2, 2);
      tbl[21] = mk(0,  4,  0,  1,   0, 0, 0, 4,  0, 0, 3, 2, 1);
      tbl[22] = mk(0,  8,  0,  0,   0, 0, 0, 0,  0, 1, 3, 3, 1);
      tbl[23] = mk(0,  8,  0,  2,   0, 0, 8, 0,  0, 0, 3, 3, 1);
      tbl[24] = mk(0,  8,  0,  1,   0, 0, 0, 8,  0, 0, 3, 3, 0);
      // stray handshakes in idle states and a reject for an idle core
      tbl[25] = mk(0,  0,  1, 15,   0, 0, 0, 0,  0, 0, 3, 3, 0);

      rst = 1'b1;
      core_rdy_for_sn = '0; core_rdy_for_fwd = '0; core_rej = '0;
      rdy_for_sn_ack = 1'b0; sn_done = 1'b0;
      rdy_for_fwd_ack = 1'b0; fwd_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
      rst = 1'b0;

      for (int i = 0; i < 26; i++) step($sformatf("tbl[%0d]", i), tbl[i]);

      // round-robin resumes after the last grant; withdrawn offer
      step("rr_grant2",     mk(4,0,0,0, 0,0,0,0, 1,0,2,3,0));
      step("rr_ack2",       mk(4,0,0,8, 4,0,0,0, 0,0,2,3,0));
      step("rr_done2",      mk(4,0,0,4, 0,4,0,0, 0,0,2,3,1));
      step("rr_grant3",     mk(9,0,0,0, 0,0,0,0, 1,0,3,3,1));
      step("rr_ack3",       mk(9,0,0,8, 8,0,0,0, 0,0,3,3,1));
      step("rr_done3",      mk(9,0,0,4, 0,8,0,0, 0,0,3,3,2));
      step("rr_grant0",     mk(9,0,0,0, 0,0,0,0, 1,0,0,3,2));
      step("withdraw",      mk(0,0,0,0, 0,0,0,0, 0,0,0,3,2));
      step("reoffer0",      mk(1,0,0,0, 0,0,0,0, 1,0,0,3,2));
      // snoop busy on core 0 while forwarding core 2; done pulses coincide
      step("ack0_offer2",   mk(1,4,0,8, 1,0,0,0, 0,1,0,2,2));
      step("fwd_ack2",      mk(0,4,0,2, 0,0,4,0, 0,0,0,2,2));
      step("push_pop_same", mk(0,0,0,5, 0,1,0,4, 0,0,0,2,2));
      step("offer3",        mk(0,9,0,0, 0,0,0,0, 0,1,0,3,2));
      step("fwd_ack3",      mk(0,9,0,2, 0,0,8,0, 0,0,0,3,2));
      step("fwd_done3",     mk(0,9,0,1, 0,0,0,8, 0,0,0,3,1));
      step("offer0_noskip", mk(0,9,0,0, 0,0,0,0, 0,1,0,0,1));
      // drive both FSMs into BUSY, then reset between edges
      step("fwbusy_offer1", mk(2,9,0,2, 0,0,1,0, 1,0,1,0,1));
      step("snbusy1",       mk(2,9,0,8, 2,0,0,0, 0,0,1,0,1));
      #2;
      rst = 1'b1;
      core_rdy_for_sn = '0; core_rdy_for_fwd = '0;
      rdy_for_sn_ack = 1'b0; rdy_for_fwd_ack = 1'b0;
      #1;
      check("async_reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
      #2;
      rst = 1'b0;
      step("post_reset_grant0", mk(15,0,0,0, 0,0,0,0, 1,0,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
